// File: rtl/riscv_retire_checker_if.sv
// Bundle between the RISC-V retire stream / table loader and the retire checker.
// The master side drives the table, START and the core retire signals; the checker observes them.
interface riscv_retire_checker_if #(
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned DWIDTH = 32
);
   logic                TBL_WE;
   logic [IDX_W-1:0]    TBL_WA;
   logic [DWIDTH-1:0]   TBL_NUM;
   logic [DWIDTH-1:0]   TBL_ANS;
   logic [IDX_W:0]      TBL_CNT;
   logic                START;
   logic [DWIDTH-1:0]   NUM_INST;
   logic [DWIDTH-1:0]   OUTPUT_PORT;
   logic                HALT;

   logic                BUSY;
   logic                DONE;
   logic                PASS;
   logic                FAIL;
   logic [IDX_W:0]      PASS_CNT;
   logic [IDX_W-1:0]    FAIL_IDX;
   logic [DWIDTH-1:0]   FAIL_VAL;
   logic [DWIDTH-1:0]   CYCLE;

   modport master (
      output TBL_WE, TBL_WA, TBL_NUM, TBL_ANS, TBL_CNT, START,
             NUM_INST, OUTPUT_PORT, HALT,
      input  BUSY, DONE, PASS, FAIL, PASS_CNT, FAIL_IDX, FAIL_VAL, CYCLE
   );

   modport slave (
      input  TBL_WE, TBL_WA, TBL_NUM, TBL_ANS, TBL_CNT, START,
             NUM_INST, OUTPUT_PORT, HALT,
      output BUSY, DONE, PASS, FAIL, PASS_CNT, FAIL_IDX, FAIL_VAL, CYCLE
   );
endinterface

// File: rtl/riscv_retire_checker.sv
// On-chip retire-stream checker: compares the core's (NUM_INST, OUTPUT_PORT) stream
// against a programmable table of expected pairs and reports PASS/FAIL status.
module riscv_retire_checker #(
   parameter int unsigned NUM_TEST = 22,
   parameter int unsigned IDX_W    = 5,
   parameter int unsigned DWIDTH   = 32
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   riscv_retire_checker_if.slave bus
);

   localparam int unsigned CW = IDX_W + 1;

   typedef struct packed {
      logic [DWIDTH-1:0] num;
      logic [DWIDTH-1:0] ans;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     tcnt_q, tcnt_d;
   logic [CW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     pass_cnt_q, pass_cnt_d;
   logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
   logic [DWIDTH-1:0] fail_val_q, fail_val_d;
   logic [DWIDTH-1:0] cycle_q, cycle_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;

   entry_t            tbl_q [NUM_TEST];
   entry_t            cur_c;
   logic              tbl_we_c;
   logic              have_c;
   logic              hit_c;
   logic              mis_c;
   logic              skip_c;
   logic [CW-1:0]     tcnt_lim_c;
   logic [CW-1:0]     ptr_post_c;
   logic [CW-1:0]     pass_post_c;

   // Table is loadable only while idle and only for in-range indices.
   assign tbl_we_c = (state_q == S_IDLE) && bus.TBL_WE &&
                     (32'(bus.TBL_WA) < 32'(NUM_TEST));

   always_ff @(posedge CLK) begin
      if (tbl_we_c) begin
         tbl_q[bus.TBL_WA] <= '{num: bus.TBL_NUM, ans: bus.TBL_ANS};
      end
   end

   assign tcnt_lim_c = (32'(bus.TBL_CNT) > 32'(NUM_TEST)) ? CW'(NUM_TEST) : bus.TBL_CNT;

   // cur_c is only meaningful while ptr_q < tcnt_q, which keeps the index inside the table.
   assign have_c = (ptr_q < tcnt_q);
   assign cur_c  = have_c ? tbl_q[ptr_q[IDX_W-1:0]] : '0;
   assign hit_c  = have_c && (bus.NUM_INST == cur_c.num);
   assign mis_c  = hit_c && (bus.OUTPUT_PORT != cur_c.ans);
   assign skip_c = have_c && (bus.NUM_INST > cur_c.num);

   assign ptr_post_c  = ptr_q + CW'(hit_c && !mis_c);
   assign pass_post_c = pass_cnt_q + CW'(hit_c && !mis_c);

   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      ptr_d      = ptr_q;
      pass_cnt_d = pass_cnt_q;
      fail_idx_d = fail_idx_q;
      fail_val_d = fail_val_q;
      cycle_d    = cycle_q;

      if (bus.START) begin
         state_d    = S_RUN;
         tcnt_d     = tcnt_lim_c;
         ptr_d      = '0;
         pass_cnt_d = '0;
         cycle_d    = '0;
         fail_idx_d = '0;
         fail_val_d = '0;
      end else begin
         case (state_q)
            S_RUN: begin
               cycle_d = cycle_q + DWIDTH'(1);
               if (mis_c || skip_c) begin
                  state_d    = S_FAIL;
                  fail_idx_d = ptr_q[IDX_W-1:0];
                  fail_val_d = bus.OUTPUT_PORT;
               end else begin
                  ptr_d      = ptr_post_c;
                  pass_cnt_d = pass_post_c;
                  // A halt with entries still outstanding fails on the first untested one.
                  if (bus.HALT) begin
                     if (pass_post_c == tcnt_q) begin
                        state_d = S_PASS;
                     end else begin
                        state_d    = S_FAIL;
                        fail_idx_d = ptr_post_c[IDX_W-1:0];
                        fail_val_d = bus.OUTPUT_PORT;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_PASS) || (state_d == S_FAIL);
      pass_d = (state_d == S_PASS);
      fail_d = (state_d == S_FAIL);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= S_IDLE;
         tcnt_q     <= '0;
         ptr_q      <= '0;
         pass_cnt_q <= '0;
         fail_idx_q <= '0;
         fail_val_q <= '0;
         cycle_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tcnt_q     <= tcnt_d;
         ptr_q      <= ptr_d;
         pass_cnt_q <= pass_cnt_d;
         fail_idx_q <= fail_idx_d;
         fail_val_q <= fail_val_d;
         cycle_q    <= cycle_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
      end
   end

   assign bus.BUSY     = busy_q;
   assign bus.DONE     = done_q;
   assign bus.PASS     = pass_q;
   assign bus.FAIL     = fail_q;
   assign bus.PASS_CNT = pass_cnt_q;
   assign bus.FAIL_IDX = fail_idx_q;
   assign bus.FAIL_VAL = fail_val_q;
   assign bus.CYCLE    = cycle_q;

endmodule
